stream_min_max: RTL and testbench

//   Streaming min/max tracker; consumes samples one per handshake and compares each against running extremes.

---
 rtl/stream_min_max.sv | 114 +++++++++++
 tb/tb_stream_min_max.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_min_max.sv
// Streaming min/max tracker.
// Consumes unsigned samples one per handshake and keeps the running minimum
// and maximum, their first-occurrence indices and a saturating sample count.
// A frame closes on i_last; the result is then held until the downstream
// consumer takes it, after which the next frame can start.
module stream_min_max #(
  parameter int N           = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N-1:0]           i_data,
  input  logic                   i_last,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [N-1:0]           o_min,
  output logic [N-1:0]           o_max,
  output logic [COUNT_WIDTH-1:0] o_min_index,
  output logic [COUNT_WIDTH-1:0] o_max_index,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_saturated
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_t state;
  logic   first;
  logic   accept;
  logic   handoff;
  logic   data_less;
  logic   data_greater;
  logic   count_full;

  // Handshake decode plus the unsigned comparisons against the stored extremes.
  always_comb begin
    o_ready      = (state == ACCUM) && !i_reset;
    accept       = i_valid && o_ready;
    handoff      = o_valid && i_ready;
    data_less    = i_data < o_min;
    data_greater = i_data > o_max;
    count_full   = (o_count == COUNT_MAX);
  end

  // Frame state machine; the result registers double as the running extremes,
  // so they keep the previous frame's values until the next first sample lands.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= ACCUM;
      first       <= 1'b1;
      o_valid     <= 1'b0;
      o_min       <= '0;
      o_max       <= '0;
      o_min_index <= '0;
      o_max_index <= '0;
      o_count     <= '0;
      o_saturated <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (first) begin
              o_min       <= i_data;
              o_max       <= i_data;
              o_min_index <= '0;
              o_max_index <= '0;
              o_count     <= COUNT_ONE;
              o_saturated <= 1'b0;
              first       <= 1'b0;
            end else begin
              // The index of a new extreme is the count before this sample,
              // which pins at all-ones once the counter has saturated.
              if (data_less) begin
                o_min       <= i_data;
                o_min_index <= o_count;
              end
              if (data_greater) begin
                o_max       <= i_data;
                o_max_index <= o_count;
              end
              if (count_full) begin
                o_saturated <= 1'b1;
              end else begin
                o_count <= o_count + COUNT_ONE;
              end
            end
            if (i_last) begin
              state   <= HOLD;
              o_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (handoff) begin
            state   <= ACCUM;
            first   <= 1'b1;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_min_max.sv
// Directed bench for stream_min_max: a default-width instance and a 2-bit
// count instance share one stimulus stream, so the saturation frame can be
// checked alongside the full-width result of the same samples.
module tb_stream_min_max;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready_in;

  logic       a_ready, a_valid, a_sat;
  logic [7:0] a_min, a_max, a_min_idx, a_max_idx, a_count;

  logic       b_ready, b_valid, b_sat;
  logic [7:0] b_min, b_max;
  logic [1:0] b_min_idx, b_max_idx, b_count;

  int checks;
  int errors;

  stream_min_max #(.N(8), .COUNT_WIDTH(8)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_valid     (in_valid),
    .o_ready     (a_ready),
    .i_data      (in_data),
    .i_last      (in_last),
    .o_valid     (a_valid),
    .i_ready     (out_ready_in),
    .o_min       (a_min),
    .o_max       (a_max),
    .o_min_index (a_min_idx),
    .o_max_index (a_max_idx),
    .o_count     (a_count),
    .o_saturated (a_sat)
  );

  stream_min_max #(.N(8), .COUNT_WIDTH(2)) dut_small (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_valid     (in_valid),
    .o_ready     (b_ready),
    .i_data      (in_data),
    .i_last      (in_last),
    .o_valid     (b_valid),
    .i_ready     (out_ready_in),
    .o_min       (b_min),
    .o_max       (b_max),
    .o_min_index (b_min_idx),
    .o_max_index (b_max_idx),
    .o_count     (b_count),
    .o_saturated (b_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample on the falling edge and let the next rising edge take it.
  task automatic send(input logic [7:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
  endtask

  // Drop valid on the falling edge after the last accept.
  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // Release a held result with a single-cycle downstream ready.
  task automatic do_handoff();
    out_ready_in = 1'b1;
    @(negedge clk);
    out_ready_in = 1'b0;
    checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL handoff: valid=%0b ready=%0b, required valid=0 ready=1", a_valid, a_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready_in = 1'b0;
    #12;
    checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b0 || a_min !== 8'd0 || a_max !== 8'd0 ||
        a_min_idx !== 8'd0 || a_max_idx !== 8'd0 || a_count !== 8'd0 || a_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%0b ready=%0b min=%0d max=%0d cnt=%0d sat=%0b, required all 0",
               a_valid, a_ready, a_min, a_max, a_count, a_sat);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %0b, required 1", a_ready);
    end
  endtask

  task automatic test_basic_frame();
    send(8'd5, 1'b0);
    send(8'd3, 1'b0);
    send(8'd9, 1'b0);
    send(8'd3, 1'b0);
    send(8'd9, 1'b1);
    go_idle();
    checks++;
    if (a_valid !== 1'b1 || a_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_latency: valid=%0b ready=%0b, required valid=1 ready=0", a_valid, a_ready);
    end
    checks++;
    if (a_min !== 8'd3 || a_min_idx !== 8'd1 || a_max !== 8'd9 || a_max_idx !== 8'd2) begin
      errors++;
      $display("[TB] FAIL t1_extremes: min=%0d@%0d max=%0d@%0d, required min=3@1 max=9@2",
               a_min, a_min_idx, a_max, a_max_idx);
    end
    checks++;
    if (a_count !== 8'd5 || a_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t1_count: count=%0d sat=%0b, required count=5 sat=0", a_count, a_sat);
    end
    do_handoff();
  endtask

  task automatic test_single_sample();
    send(8'h7F, 1'b1);
    go_idle();
    checks++;
    if (a_valid !== 1'b1 || a_min !== 8'h7F || a_max !== 8'h7F || a_min_idx !== 8'd0 ||
        a_max_idx !== 8'd0 || a_count !== 8'd1 || a_sat !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t2_single: valid=%0b min=%0h@%0d max=%0h@%0d cnt=%0d, required 1 7f@0 7f@0 1",
               a_valid, a_min, a_min_idx, a_max, a_max_idx, a_count);
    end
    do_handoff();
  endtask

  task automatic test_hold_stall();
    send(8'd5, 1'b0);
    send(8'd3, 1'b0);
    send(8'd9, 1'b0);
    send(8'd3, 1'b0);
    send(8'd9, 1'b1);
    go_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0);
      in_data  = 8'd1 + 8'(i);
      in_last  = 1'b1;
      #1;
      checks++;
      if (a_valid !== 1'b1 || a_ready !== 1'b0 || a_min !== 8'd3 || a_min_idx !== 8'd1 ||
          a_max !== 8'd9 || a_max_idx !== 8'd2 || a_count !== 8'd5) begin
        errors++;
        $display("[TB] FAIL t3_stall_%0d: valid=%0b ready=%0b min=%0d@%0d max=%0d@%0d cnt=%0d, required 1 0 3@1 9@2 5",
                 i, a_valid, a_ready, a_min, a_min_idx, a_max, a_max_idx, a_count);
      end
    end
    go_idle();
    do_handoff();
  endtask

  task automatic test_saturation();
    send(8'd4, 1'b0);
    send(8'd4, 1'b0);
    send(8'd1, 1'b0);
    send(8'd8, 1'b0);
    send(8'd2, 1'b0);
    send(8'd0, 1'b1);
    go_idle();
    checks++;
    if (b_valid !== 1'b1 || b_count !== 2'd3 || b_sat !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t4_sat_count: valid=%0b count=%0d sat=%0b, required 1 3 1", b_valid, b_count, b_sat);
    end
    checks++;
    if (b_min !== 8'd0 || b_min_idx !== 2'd3 || b_max !== 8'd8 || b_max_idx !== 2'd3) begin
      errors++;
      $display("[TB] FAIL t4_sat_extremes: min=%0d@%0d max=%0d@%0d, required 0@3 8@3",
               b_min, b_min_idx, b_max, b_max_idx);
    end
    checks++;
    if (a_count !== 8'd6 || a_sat !== 1'b0 || a_min !== 8'd0 || a_min_idx !== 8'd5 ||
        a_max !== 8'd8 || a_max_idx !== 8'd3) begin
      errors++;
      $display("[TB] FAIL t4_wide: min=%0d@%0d max=%0d@%0d cnt=%0d sat=%0b, required 0@5 8@3 6 0",
               a_min, a_min_idx, a_max, a_max_idx, a_count, a_sat);
    end
    do_handoff();
  endtask

  task automatic test_reset_mid_frame();
    send(8'd40, 1'b0);
    send(8'd50, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (a_min !== 8'd0 || a_max !== 8'd0 || a_count !== 8'd0 || a_valid !== 1'b0 || a_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL t5_reset_clear: min=%0d max=%0d cnt=%0d valid=%0b ready=%0b, required all 0",
               a_min, a_max, a_count, a_valid, a_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'd6, 1'b0);
    send(8'd2, 1'b1);
    go_idle();
    checks++;
    if (a_valid !== 1'b1 || a_min !== 8'd2 || a_min_idx !== 8'd1 || a_max !== 8'd6 ||
        a_max_idx !== 8'd0 || a_count !== 8'd2) begin
      errors++;
      $display("[TB] FAIL t5_next_frame: valid=%0b min=%0d@%0d max=%0d@%0d cnt=%0d, required 1 2@1 6@0 2",
               a_valid, a_min, a_min_idx, a_max, a_max_idx, a_count);
    end
    // A reset while the result is held must drop o_valid without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (a_valid !== 1'b0 || a_min !== 8'd0) begin
      errors++;
      $display("[TB] FAIL t5_reset_hold: valid=%0b min=%0d, required valid=0 min=0", a_valid, a_min);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] samples [6];
    logic [7:0] r_min [2];
    logic [7:0] r_max [2];
    logic [7:0] r_min_idx [2];
    logic [7:0] r_max_idx [2];
    logic [7:0] r_cnt [2];
    int k;
    int cycles;
    int nres;
    logic will_accept;
    samples[0] = 8'd10; samples[1] = 8'd20; samples[2] = 8'd30;
    samples[3] = 8'd7;  samples[4] = 8'd7;  samples[5] = 8'd1;
    for (int i = 0; i < 2; i++) begin
      r_min[i] = 8'hEE; r_max[i] = 8'hEE; r_min_idx[i] = 8'hEE; r_max_idx[i] = 8'hEE; r_cnt[i] = 8'hEE;
    end
    k = 0; cycles = 0; nres = 0;
    out_ready_in = 1'b1;
    while (k < 6 && cycles < 20) begin
      @(negedge clk);
      if (a_valid && nres < 2) begin
        r_min[nres] = a_min; r_max[nres] = a_max;
        r_min_idx[nres] = a_min_idx; r_max_idx[nres] = a_max_idx; r_cnt[nres] = a_count;
        nres++;
      end
      in_valid = 1'b1;
      in_data  = samples[k];
      in_last  = (k == 2) || (k == 5);
      will_accept = a_ready;
      @(posedge clk);
      if (will_accept) k++;
      cycles++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (a_valid && nres < 2) begin
      r_min[nres] = a_min; r_max[nres] = a_max;
      r_min_idx[nres] = a_min_idx; r_max_idx[nres] = a_max_idx; r_cnt[nres] = a_count;
      nres++;
    end
    @(negedge clk);
    out_ready_in = 1'b0;
    checks++;
    if (k != 6 || cycles != 7) begin
      errors++;
      $display("[TB] FAIL t6_cycles: accepted=%0d cycles=%0d, required accepted=6 cycles=7", k, cycles);
    end
    checks++;
    if (nres != 2) begin
      errors++;
      $display("[TB] FAIL t6_results: got %0d results, required 2", nres);
    end
    checks++;
    if (r_min[0] !== 8'd10 || r_min_idx[0] !== 8'd0 || r_max[0] !== 8'd30 ||
        r_max_idx[0] !== 8'd2 || r_cnt[0] !== 8'd3) begin
      errors++;
      $display("[TB] FAIL t6_frame_a: min=%0d@%0d max=%0d@%0d cnt=%0d, required 10@0 30@2 3",
               r_min[0], r_min_idx[0], r_max[0], r_max_idx[0], r_cnt[0]);
    end
    checks++;
    if (r_min[1] !== 8'd1 || r_min_idx[1] !== 8'd2 || r_max[1] !== 8'd7 ||
        r_max_idx[1] !== 8'd0 || r_cnt[1] !== 8'd3) begin
      errors++;
      $display("[TB] FAIL t6_frame_b: min=%0d@%0d max=%0d@%0d cnt=%0d, required 1@2 7@0 3",
               r_min[1], r_min_idx[1], r_max[1], r_max_idx[1], r_cnt[1]);
    end
    checks++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL t6_idle: valid=%0b ready=%0b, required valid=0 ready=1", a_valid, a_ready);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_frame();
    test_single_sample();
    test_hold_stall();
    test_saturation();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
